// File: rtl/boot_pkg.sv
// Shared types and helpers for the boot sequencer.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN,
        ST_FAULT
    } boot_state_t;

    // One-hot byte-lane enable for a byte address offset within a word.
    function automatic logic [3:0] byte_lane(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/boot_counter.sv
// Loadable up/down counter with clear and a terminal-value flag.
module boot_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TERM  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic             down,
    output logic             term_c
);

    logic [WIDTH-1:0] count;

    // Priority: clear, load, increment, decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            if (clr) begin
                count <= '0;
            end else if (load) begin
                count <= load_val;
            end else if (up) begin
                count <= count + WIDTH'(1);
            end else if (down) begin
                count <= count - WIDTH'(1);
            end
        end
    end

    assign term_c = (count == WIDTH'(TERM));

endmodule

// File: rtl/boot_ctrl.sv
// Boot sequencer: streams the UART image into memory, then releases the CPU
// and hands it the memory write port.
module boot_ctrl #(
    parameter int unsigned     CLOCK_RATE     = 25175000,
    parameter longint unsigned MEM_BYTES      = 65536,
    parameter int unsigned     RELEASE_CYCLES = 16,
    parameter int unsigned     TIMEOUT_CYCLES = CLOCK_RATE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_enable,
    input  logic        up_we,
    input  logic [31:0] up_addr,
    input  logic [7:0]  up_data,
    input  logic        up_complete,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        error,
    output logic        overflow
);

    import boot_pkg::*;

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned ST_W = $clog2(RELEASE_CYCLES) + 1;

    boot_state_t state_q, state_d;
    logic [1:0]  rst_sync;
    logic        step;
    logic        up_in_range;
    logic        to_clr, to_inc, to_term_c;
    logic        st_load, st_dec, st_term_c;
    logic        mem_we_d, cpu_rst_n_d, busy_d, error_d, overflow_d;
    logic [29:0] mem_addr_d;
    logic [31:0] mem_wdata_d;
    logic [3:0]  mem_be_d;
    logic        unused_c;

    assign unused_c = ^{cpu_addr[1:0], 32'(CLOCK_RATE)};

    // Reset deassertion is resynchronised; assertion stays asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign step        = clk_enable & rst_sync[1];
    assign up_in_range = ({1'b0, up_addr} < 33'(MEM_BYTES));

    boot_counter #(.WIDTH(TO_W), .TERM(TIMEOUT_CYCLES - 1)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (step),
        .clr      (to_clr),
        .load     (1'b0),
        .load_val ('0),
        .up       (to_inc),
        .down     (1'b0),
        .term_c   (to_term_c)
    );

    boot_counter #(.WIDTH(ST_W), .TERM(0)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (step),
        .clr      (1'b0),
        .load     (st_load),
        .load_val (ST_W'(RELEASE_CYCLES - 1)),
        .up       (1'b0),
        .down     (st_dec),
        .term_c   (st_term_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    state_q <= ST_WAIT;
        else if (step) state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_be_d    = mem_be;
        error_d     = error;
        overflow_d  = overflow;
        to_clr      = 1'b0;
        to_inc      = 1'b0;
        st_load     = 1'b0;
        st_dec      = 1'b0;

        // Upload bytes are accepted in WAIT and LOAD; out-of-range ones only flag.
        if ((state_q == ST_WAIT || state_q == ST_LOAD) && up_we) begin
            to_clr = 1'b1;
            if (up_in_range) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = up_addr[31:2];
                mem_wdata_d = {4{up_data}};
                mem_be_d    = byte_lane(up_addr[1:0]);
            end else begin
                overflow_d = 1'b1;
            end
        end

        case (state_q)
            ST_WAIT: begin
                if (up_complete) begin
                    state_d = ST_SETTLE;
                    st_load = 1'b1;
                end else if (up_we) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (up_complete) begin
                    state_d = ST_SETTLE;
                    st_load = 1'b1;
                end else if (!up_we) begin
                    if (to_term_c) begin
                        state_d = ST_FAULT;
                        error_d = 1'b1;
                    end else begin
                        to_inc = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (st_term_c) state_d = ST_RUN;
                else           st_dec  = 1'b1;
            end
            ST_RUN: begin
                if (cpu_we) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cpu_addr[31:2];
                    mem_wdata_d = cpu_wdata;
                    mem_be_d    = cpu_be;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_WAIT;
        endcase

        cpu_rst_n_d = (state_d == ST_RUN);
        busy_d      = (state_d == ST_LOAD) || (state_d == ST_SETTLE);
    end

    // Outputs hold on disabled cycles, except mem_we which stays a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
            overflow  <= 1'b0;
        end else if (step) begin
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_be    <= mem_be_d;
            cpu_rst_n <= cpu_rst_n_d;
            busy      <= busy_d;
            error     <= error_d;
            overflow  <= overflow_d;
        end else begin
            mem_we <= 1'b0;
        end
    end

endmodule

// File: doc/boot_ctrl.md
# boot_ctrl

Boot sequencer and memory-port arbiter between the UART upload receiver and the CPU. Holds the CPU in reset while a program image streams in over UART, forwards each received byte into the 32-bit instruction/data memory as a byte-lane write, and releases the CPU after a settle delay once the upload reports completion. After release the CPU owns the memory write port exclusively. A stalled upload is detected by an inter-byte timeout and parks the block in an error state.

## Interface
- CLOCK_RATE, 25175000: clk frequency in Hz
- MEM_BYTES, 65536: memory size in bytes; power of two, 4..2^32
- RELEASE_CYCLES, 16: cycles between upload completion and CPU reset release; >= 1
- TIMEOUT_CYCLES, CLOCK_RATE: maximum idle clk_enable cycles between bytes once the first byte arrives; >= 2
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clk_enable  in  1  global clock enable, same signal driven into the upload receiver
- up_we  in  1  upload byte write strobe, one cycle per byte
- up_addr  in  32  upload byte address
- up_data  in  8  upload byte
- up_complete  in  1  upload finished, sticky
- cpu_we  in  1  CPU write request
- cpu_addr  in  32  CPU byte address, word-aligned
- cpu_wdata  in  32  CPU write data
- cpu_be  in  4  CPU byte enables
- mem_we  out  1  memory write enable
- mem_addr  out  30  memory word address
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte enables
- cpu_rst_n  out  1  CPU reset, active-low
- busy  out  1  high in LOAD and SETTLE
- error  out  1  sticky timeout flag
- overflow  out  1  sticky flag: upload byte addressed at or beyond MEM_BYTES

## Operation
- States: WAIT, LOAD, SETTLE, RUN, FAULT. Reset state WAIT.
- All state/counter updates occur only on cycles with clk_enable=1; outputs hold otherwise.
- WAIT: cpu_rst_n=0. up_we -> LOAD, byte is written. up_complete with no byte (empty image) -> SETTLE.
- LOAD: each up_we produces one write: mem_addr=up_addr[31:2], mem_wdata={4{up_data}}, mem_be=4'b0001<<up_addr[1:0]. up_addr >= MEM_BYTES: write suppressed, overflow set, state unchanged. up_complete -> SETTLE; if up_we and up_complete in same cycle, the byte is written first.
- Timeout counter: cleared on every up_we, incremented otherwise in LOAD; reaching TIMEOUT_CYCLES -> FAULT, error=1.
- SETTLE: counter loaded with RELEASE_CYCLES-1, decrements; at 0 -> RUN. up_we ignored.
- RUN: cpu_rst_n=1; cpu_we/cpu_addr[31:2]/cpu_wdata/cpu_be forwarded; upload inputs ignored. Terminal until rst_n.
- FAULT: cpu_rst_n=0, mem_we=0, terminal until rst_n. up_complete ignored.
- cpu_* inputs ignored in every state except RUN.

## Timing
- All outputs registered; reset values: mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, cpu_rst_n=0, busy=0, error=0, overflow=0.
- Upload byte -> mem_we: 1 enabled cycle latency. CPU write -> mem_we: 1 cycle latency.
- mem_we is a single-cycle pulse per accepted write.
- up_complete seen in cycle N (LOAD) -> cpu_rst_n=1 in cycle N+1+RELEASE_CYCLES.
- rst_n assertion mid-upload: immediate return to WAIT, cpu_rst_n=0, flags cleared; no partial write issued after deassertion.
- rst_n deassertion synchronised internally (two-flop) before affecting state.

## Structure
- boot_pkg: state enum boot_state_t, function byte_lane(addr[1:0]) -> 4-bit one-hot enable.
- Sub-module boot_counter: loadable down/up counter with clear and terminal flag, instantiated for timeout and settle (width $clog2 of parameter + 1).

## Test plan
- Upload 8 bytes 0x11..0x88 at addr 0..7, then up_complete -> 8 writes, words 0/1 be 1,2,4,8 each with replicated byte; cpu_rst_n rises exactly RELEASE_CYCLES+1 cycles after up_complete.
- In RUN, cpu_we with addr 0x10, data 0xDEADBEEF, be 4'b1111 -> mem_we next cycle, mem_addr=4, same data/be; up_we pulses ignored.
- Byte at up_addr=MEM_BYTES -> no mem_we, overflow=1, subsequent in-range bytes still written.
- First byte then silence for TIMEOUT_CYCLES (TIMEOUT_CYCLES=20) -> error=1, FAULT, cpu_rst_n stays 0, later up_complete ignored.
- up_we and up_complete same cycle -> byte written, then SETTLE; clk_enable held low 5 cycles during SETTLE -> release delayed by 5.
- rst_n low during LOAD -> all outputs at reset values asynchronously; new upload after deassertion behaves as first test.
